// File: rtl/gpio_pkg.sv
// Shared encodings for the GPIO pad wrappers: drive modes, input-buffer modes, irq edge select.
package gpio_pkg;

  localparam logic [2:0] DM_IN_ONLY   = 3'b001;
  localparam logic [2:0] DM_STRONG    = 3'b110;
  localparam logic [1:0] IB_MODE_CMOS = 2'b00;

  typedef enum logic [1:0] {
    IRQ_OFF  = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_sel_e;

  // Bit 0 of the select enables rising edges, bit 1 falling edges.
  function automatic logic irq_hit(input logic [1:0] sel, input logic rise, input logic fall);
    return (sel[0] & rise) | (sel[1] & fall);
  endfunction

endpackage

// File: rtl/gpio_in_debounced_if.sv
// Fabric-side bundle of the debounced GPIO input; irq pins exist only when GPIO_IN_IRQ_EN is defined.
// slave = the pad block, master = the consuming fabric logic.
interface gpio_in_debounced_if;
  wire        PAD;
  logic       Y;
  logic       Y_rise;
  logic       Y_fall;
`ifdef GPIO_IN_IRQ_EN
  logic [1:0] irq_sel;
  logic       irq_clr;
  logic       irq;

  modport slave  (inout PAD, output Y, output Y_rise, output Y_fall,
                  input irq_sel, input irq_clr, output irq);
  modport master (inout PAD, input Y, input Y_rise, input Y_fall,
                  output irq_sel, output irq_clr, input irq);
`else
  modport slave  (inout PAD, output Y, output Y_rise, output Y_fall);
  modport master (inout PAD, input Y, input Y_rise, input Y_fall);
`endif
endinterface

// File: rtl/gpio_debounce.sv
// Level debounce filter: q follows d once d has differed from q for DB_CYCLES consecutive cycles.
// Latency: DB_CYCLES edges (1 edge when DB_CYCLES=0). Backpressure: none, rise/fall are 1-cycle pulses.
module gpio_debounce #(
  parameter int unsigned DB_CYCLES = 16,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  if (DB_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk) begin
      if (rst) begin
        q    <= RESET_VAL;
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        q    <= d;
        rise <= d & ~q;
        fall <= ~d & q;
      end
    end
  end else begin : g_filter
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // cnt holds how many cycles d has already disagreed with q; it stops at LAST.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt  <= '0;
        q    <= RESET_VAL;
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (d == q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt  <= '0;
          q    <= d;
          rise <= d;
          fall <= ~d;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_in_pad.sv
// Input-path behavioural model of the sky130_fd_io__top_gpio_ovtv2 pad cell.
// Latency: combinational PAD -> IN. Backpressure: none, free-running level.
// Pin names follow the cell so the real macro can be dropped in.
module gpio_in_pad (
  inout  wire        PAD,
  input  logic       OE_N,
  input  logic       INP_DIS,
  input  logic       ENABLE_INP_H,
  input  logic       ENABLE_H,
  input  logic       HLD_H_N,
  input  logic       ENABLE_VDDIO,
  input  logic       VTRIP_SEL,
  input  logic       HYS_TRIM,
  input  logic [1:0] IB_MODE_SEL,
  input  logic [2:0] DM,
  input  logic       OUT,
  input  logic       ANALOG_EN,
  input  logic       ENABLE_VDDA_H,
  input  logic       ENABLE_VSWITCH_H,
  input  logic       HLD_OVR,
  input  logic       SLOW,
  output logic       IN,
  output logic       TIE_HI_ESD,
  output logic       TIE_LO_ESD
);

  assign TIE_HI_ESD = 1'b1;
  assign TIE_LO_ESD = 1'b0;

  // Input buffer only passes the pad when every enable in the input path is live.
  assign IN = (ENABLE_H & ENABLE_INP_H & HLD_H_N & ENABLE_VDDIO & ~INP_DIS) ? PAD : 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{OE_N, VTRIP_SEL, HYS_TRIM, IB_MODE_SEL, DM, OUT,
                        ANALOG_EN, ENABLE_VDDA_H, ENABLE_VSWITCH_H, HLD_OVR, SLOW};

endmodule

// File: rtl/gpio_in_debounced.sv
// Input-only GPIO pad, synchronizer and debounce filter; optional sticky irq under GPIO_IN_IRQ_EN.
// Latency: SYNC_STAGES+DB_CYCLES edges pad->Y, irq one edge after the edge pulse. Backpressure: none.
module gpio_in_debounced
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_in_debounced_if.slave   io
);

  logic       tie_hi;
  logic       tie_lo;
  logic       pad_in;
  logic [2:0] dm_tie;
  logic [1:0] ib_tie;

  // Multi-bit straps are built bit by bit from the ESD tie cells.
  for (genvar i = 0; i < 3; i++) begin : g_dm_tie
    assign dm_tie[i] = DM_IN_ONLY[i] ? tie_hi : tie_lo;
  end
  for (genvar i = 0; i < 2; i++) begin : g_ib_tie
    assign ib_tie[i] = IB_MODE_CMOS[i] ? tie_hi : tie_lo;
  end

  gpio_in_pad u_pad (
    .PAD              (io.PAD),
    .OE_N             (tie_hi),
    .INP_DIS          (tie_lo),
    .ENABLE_INP_H     (tie_hi),
    .ENABLE_H         (tie_hi),
    .HLD_H_N          (tie_hi),
    .ENABLE_VDDIO     (tie_hi),
    .VTRIP_SEL        (tie_lo),
    .HYS_TRIM         (tie_lo),
    .IB_MODE_SEL      (ib_tie),
    .DM               (dm_tie),
    .OUT              (tie_lo),
    .ANALOG_EN        (tie_lo),
    .ENABLE_VDDA_H    (tie_lo),
    .ENABLE_VSWITCH_H (tie_lo),
    .HLD_OVR          (tie_lo),
    .SLOW             (tie_lo),
    .IN               (pad_in),
    .TIE_HI_ESD       (tie_hi),
    .TIE_LO_ESD       (tie_lo)
  );

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  gpio_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .RESET_VAL (RESET_VAL)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .d    (sync_q[SYNC_STAGES-1]),
    .q    (io.Y),
    .rise (io.Y_rise),
    .fall (io.Y_fall)
  );

`ifdef GPIO_IN_IRQ_EN
  logic irq_q;

  // A selected edge takes priority over a clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (irq_hit(io.irq_sel, io.Y_rise, io.Y_fall)) begin
      irq_q <= 1'b1;
    end else if (io.irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign io.irq = irq_q;
`endif

endmodule

// File: tb/tb_gpio_in_debounced.sv
// Bench for gpio_in_debounced: a filtered instance (DB_CYCLES=16) and a bypass instance (DB_CYCLES=0)
// share one pad drive and are compared against a run-length reference model.
module tb_gpio_in_debounced;

  localparam int   SS = 2;
  localparam int   DB = 16;
  localparam logic RV = 1'b0;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic pad_drv = 1'b0;
`ifdef GPIO_IN_IRQ_EN
  logic [1:0] sel_drv = 2'b00;
  logic       clr_drv = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  gpio_in_debounced_if bus_a ();
  gpio_in_debounced_if bus_b ();

  assign bus_a.PAD = pad_drv;
  assign bus_b.PAD = pad_drv;
`ifdef GPIO_IN_IRQ_EN
  assign bus_a.irq_sel = sel_drv;
  assign bus_a.irq_clr = clr_drv;
  assign bus_b.irq_sel = sel_drv;
  assign bus_b.irq_clr = clr_drv;
`endif

  gpio_in_debounced #(.SYNC_STAGES(SS), .DB_CYCLES(DB), .RESET_VAL(RV)) dut_a (
    .clk (clk), .rst (rst), .io (bus_a.slave));
  gpio_in_debounced #(.SYNC_STAGES(SS), .DB_CYCLES(0), .RESET_VAL(RV)) dut_b (
    .clk (clk), .rst (rst), .io (bus_b.slave));

  always #5 clk = ~clk;

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  // Y takes the synchronized value once that value has been seen for db_of[k] cycles in a row.
  int   db_of [2] = '{DB, 0};
  logic pipe    [2][SS];
  logic m_y     [2];
  logic m_rise  [2];
  logic m_fall  [2];
  logic m_irq   [2];
  logic run_val [2];
  int   run_len [2];

  task automatic step(input logic p, input logic r);
    logic s_seen;
    logic y_old;
    pad_drv = p;
    rst     = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int i = 0; i < SS; i++) pipe[k][i] = RV;
        m_y[k] = RV; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_irq[k] = 1'b0;
        run_val[k] = RV; run_len[k] = 0;
      end else begin
        s_seen = pipe[k][SS-1];
        for (int i = SS - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = p;
`ifdef GPIO_IN_IRQ_EN
        if ((sel_drv == 2'b01 || sel_drv == 2'b11) && m_rise[k]) m_irq[k] = 1'b1;
        else if ((sel_drv == 2'b10 || sel_drv == 2'b11) && m_fall[k]) m_irq[k] = 1'b1;
        else if (clr_drv) m_irq[k] = 1'b0;
`endif
        if (s_seen == run_val[k]) begin
          if (run_len[k] < 1000) run_len[k]++;
        end else begin
          run_val[k] = s_seen;
          run_len[k] = 1;
        end
        y_old = m_y[k];
        if (s_seen != y_old && run_len[k] >= db_of[k]) m_y[k] = s_seen;
        m_rise[k] = m_y[k] & ~y_old;
        m_fall[k] = ~m_y[k] & y_old;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    total++;
    if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall} !== {RV, 2'b00}) begin
      bad++; $display("FAIL reset_a got=%b exp=%b", {bus_a.Y, bus_a.Y_rise, bus_a.Y_fall}, {RV, 2'b00});
    end
    total++;
    if ({bus_b.Y, bus_b.Y_rise, bus_b.Y_fall} !== {RV, 2'b00}) begin
      bad++; $display("FAIL reset_b got=%b exp=%b", {bus_b.Y, bus_b.Y_rise, bus_b.Y_fall}, {RV, 2'b00});
    end
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (bus_a.irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b exp=0", bus_a.irq);
    end
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_latency();
    int first_y = -1;
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      total++;
      if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall} !== {m_y[0], m_rise[0], m_fall[0]}) begin
        bad++; $display("FAIL latency_a edge=%0d got=%b exp=%b", e,
                        {bus_a.Y, bus_a.Y_rise, bus_a.Y_fall}, {m_y[0], m_rise[0], m_fall[0]});
      end
      if (first_y < 0 && bus_a.Y === 1'b1) first_y = e;
    end
    total++;
    if (first_y != SS + DB) begin
      bad++; $display("FAIL latency_edge got=%0d exp=%0d", first_y, SS + DB);
    end
  endtask

  task automatic test_glitch();
    int rises;
    for (int len = DB - 1; len <= DB; len++) begin
      rises = 0;
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
      for (int i = 0; i < len + 30; i++) begin
        step(i < len, 1'b0);
        total++;
        if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall} !== {m_y[0], m_rise[0], m_fall[0]}) begin
          bad++; $display("FAIL glitch%0d cyc=%0d got=%b exp=%b", len, i,
                          {bus_a.Y, bus_a.Y_rise, bus_a.Y_fall}, {m_y[0], m_rise[0], m_fall[0]});
        end
        if (bus_a.Y_rise === 1'b1) rises++;
      end
      total++;
      if (rises != ((len == DB) ? 1 : 0)) begin
        bad++; $display("FAIL glitch%0d_rises got=%0d exp=%0d", len, rises, (len == DB) ? 1 : 0);
      end
    end
  endtask

  task automatic test_chatter();
    int rises  = 0;
    int rise_e = -1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(i < 5, 1'b0);
        if (bus_a.Y_rise === 1'b1) rises++;
      end
    end
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      total++;
      if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall} !== {m_y[0], m_rise[0], m_fall[0]}) begin
        bad++; $display("FAIL chatter edge=%0d got=%b exp=%b", e,
                        {bus_a.Y, bus_a.Y_rise, bus_a.Y_fall}, {m_y[0], m_rise[0], m_fall[0]});
      end
      if (bus_a.Y_rise === 1'b1) begin
        rises++;
        rise_e = e;
      end
    end
    total++;
    if (rises != 1 || rise_e != SS + DB) begin
      bad++; $display("FAIL chatter_rise count=%0d edge=%0d exp_count=1 exp_edge=%0d", rises, rise_e, SS + DB);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int first_y = -1;
    for (int i = 0; i < SS + 10; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    total++;
    if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall} !== {RV, 2'b00}) begin
      bad++; $display("FAIL mid_reset got=%b exp=%b", {bus_a.Y, bus_a.Y_rise, bus_a.Y_fall}, {RV, 2'b00});
    end
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      total++;
      if (bus_a.Y !== m_y[0]) begin
        bad++; $display("FAIL mid_reset_y edge=%0d got=%b exp=%b", e, bus_a.Y, m_y[0]);
      end
      if (first_y < 0 && bus_a.Y === 1'b1) first_y = e;
    end
    total++;
    if (first_y != SS + DB) begin
      bad++; $display("FAIL mid_reset_delay got=%0d exp=%0d", first_y, SS + DB);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic last_rise = 1'b0;
    int   pulses    = 0;
    for (int i = 0; i < 36; i++) begin
      step(((i / 3) % 2) == 0, 1'b0);
      total++;
      if ({bus_b.Y, bus_b.Y_rise, bus_b.Y_fall} !== {m_y[1], m_rise[1], m_fall[1]}) begin
        bad++; $display("FAIL bypass cyc=%0d got=%b exp=%b", i,
                        {bus_b.Y, bus_b.Y_rise, bus_b.Y_fall}, {m_y[1], m_rise[1], m_fall[1]});
      end
      if (bus_b.Y_rise === 1'b1 || bus_b.Y_fall === 1'b1) begin
        total++;
        if ((pulses > 0 && bus_b.Y_rise === last_rise) || (bus_b.Y_rise & bus_b.Y_fall)) begin
          bad++; $display("FAIL bypass_alt cyc=%0d rise=%b fall=%b prev_rise=%b", i,
                          bus_b.Y_rise, bus_b.Y_fall, last_rise);
        end
        last_rise = bus_b.Y_rise;
        pulses++;
      end
    end
    total++;
    if (pulses < 10) begin
      bad++; $display("FAIL bypass_pulses got=%0d exp>=10", pulses);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic v;
    int   hold;
    for (int seg = 0; seg < 250; seg++) begin
      v    = 1'($urandom_range(0, 1));
      hold = (seg % 4 == 0) ? int'($urandom_range(DB - 2, DB + 2)) : int'($urandom_range(1, 40));
`ifdef GPIO_IN_IRQ_EN
      sel_drv = 2'($urandom_range(0, 3));
`endif
      for (int i = 0; i < hold; i++) begin
`ifdef GPIO_IN_IRQ_EN
        clr_drv = ($urandom_range(0, 7) == 0);
`endif
        step(v, 1'b0);
        total++;
        if ({bus_a.Y, bus_a.Y_rise, bus_a.Y_fall, bus_b.Y, bus_b.Y_rise, bus_b.Y_fall} !==
            {m_y[0], m_rise[0], m_fall[0], m_y[1], m_rise[1], m_fall[1]}) begin
          bad++; $display("FAIL random seg=%0d got=%b%b%b_%b%b%b exp=%b%b%b_%b%b%b", seg,
                          bus_a.Y, bus_a.Y_rise, bus_a.Y_fall, bus_b.Y, bus_b.Y_rise, bus_b.Y_fall,
                          m_y[0], m_rise[0], m_fall[0], m_y[1], m_rise[1], m_fall[1]);
        end
`ifdef GPIO_IN_IRQ_EN
        total++;
        if ({bus_a.irq, bus_b.irq} !== {m_irq[0], m_irq[1]}) begin
          bad++; $display("FAIL random_irq seg=%0d got=%b%b exp=%b%b", seg, bus_a.irq, bus_b.irq, m_irq[0], m_irq[1]);
        end
`endif
      end
    end
`ifdef GPIO_IN_IRQ_EN
    clr_drv = 1'b0;
    sel_drv = 2'b00;
`endif
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
  endtask

`ifdef GPIO_IN_IRQ_EN
  task automatic test_irq();
    bit seen;
    sel_drv = 2'b00;
    clr_drv = 1'b1;
    step(1'b0, 1'b0);
    clr_drv = 1'b0;
    sel_drv = 2'b10;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    total++;
    if (bus_a.Y !== 1'b1 || bus_a.irq !== 1'b0) begin
      bad++; $display("FAIL irq_rise y=%b irq=%b exp y=1 irq=0", bus_a.Y, bus_a.irq);
    end
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
    total++;
    if (bus_a.irq !== 1'b1) begin
      bad++; $display("FAIL irq_fall got=%b exp=1", bus_a.irq);
    end
    clr_drv = 1'b1;
    step(1'b0, 1'b0);
    clr_drv = 1'b0;
    total++;
    if (bus_a.irq !== 1'b0) begin
      bad++; $display("FAIL irq_clr got=%b exp=0", bus_a.irq);
    end
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0);
      seen = (bus_a.Y_fall === 1'b1);
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL irq_fall_timeout got=no_fall exp=fall");
    end
    clr_drv = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if (bus_a.irq !== 1'b1) begin
      bad++; $display("FAIL irq_set_wins got=%b exp=1", bus_a.irq);
    end
    step(1'b0, 1'b0);
    clr_drv = 1'b0;
    total++;
    if (bus_a.irq !== 1'b0) begin
      bad++; $display("FAIL irq_clr_alone got=%b exp=0", bus_a.irq);
    end
    sel_drv = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_chatter();
    test_reset_mid();
    test_bypass();
`ifdef GPIO_IN_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
